// File: rtl/data_sram_resp_if.sv
// Data-SRAM request/response bus shared by the CPU side (master) and the
// SRAM/MMIO responder (slave).
interface data_sram_resp_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        input  data_sram_rdata
    );

    modport slave (
        input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        output data_sram_rdata
    );
endinterface

// File: rtl/data_sram_resp.sv
// Data SRAM responder: word RAM with byte lanes plus a small MMIO window
// holding LED, SWITCH, a free-running TIMER, COMPARE and a sticky IRQ flag.
module data_sram_resp #(
    parameter int unsigned ADDR_W    = 10,
    parameter logic [31:0] MMIO_BASE = 32'hBFAF_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    data_sram_resp_if.slave        bus,
    input  logic [7:0]             switch,
    output logic [15:0]            led,
    output logic                   timer_irq
);
    localparam logic [13:0] OFF_LED     = 14'h0;
    localparam logic [13:0] OFF_SWITCH  = 14'h1;
    localparam logic [13:0] OFF_TIMER   = 14'h2;
    localparam logic [13:0] OFF_COMPARE = 14'h3;
    localparam logic [13:0] OFF_IRQ     = 14'h4;

    logic [31:0] mem [2**ADDR_W];

    logic [31:0] rdata_q, rdata_d;
    logic [15:0] led_q, led_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] compare_q, compare_d;
    logic        irq_q, irq_d;

    logic              is_mmio, rd_en, wr_en, mmio_wr;
    logic [ADDR_W-1:0] word_idx;
    logic [13:0]       mmio_off;
    logic [31:0]       mmio_rdata, led_merged;
    logic              irq_set, irq_clr;
    logic              unused_addr_lsbs;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
        byte_merge = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) byte_merge[8*i +: 8] = new_v[8*i +: 8];
        end
    endfunction

    assign is_mmio  = (bus.data_sram_addr[31:16] == MMIO_BASE[31:16]);
    assign word_idx = bus.data_sram_addr[ADDR_W+1:2];
    assign mmio_off = bus.data_sram_addr[15:2];
    assign rd_en    = bus.data_sram_en && (bus.data_sram_wen == 4'h0);
    assign wr_en    = bus.data_sram_en && (bus.data_sram_wen != 4'h0);
    assign mmio_wr  = wr_en && is_mmio;
    assign unused_addr_lsbs = ^bus.data_sram_addr[1:0];

    // MMIO reads see register values as they stand before the request edge.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        mmio_rdata = 32'h0;
        case (mmio_off)
            OFF_LED:     mmio_rdata = {16'h0, led_q};
            OFF_SWITCH:  mmio_rdata = {24'h0, switch};
            OFF_TIMER:   mmio_rdata = timer_q;
            OFF_COMPARE: mmio_rdata = compare_q;
            OFF_IRQ:     mmio_rdata = {31'h0, irq_q};
            default:     mmio_rdata = 32'h0;
        endcase
    end

    // NOTE: combinational next-state uses blocking '='; the flops below use '<='.
    always_comb begin
        rdata_d    = rdata_q;
        led_d      = led_q;
        timer_d    = timer_q + 32'd1;
        compare_d  = compare_q;
        led_merged = byte_merge({16'h0, led_q}, bus.data_sram_wdata, bus.data_sram_wen);

        if (rd_en) rdata_d = is_mmio ? mmio_rdata : mem[word_idx];

        if (mmio_wr) begin
            case (mmio_off)
                OFF_LED:     led_d     = led_merged[15:0];
                OFF_TIMER:   timer_d   = byte_merge(timer_q, bus.data_sram_wdata, bus.data_sram_wen);
                OFF_COMPARE: compare_d = byte_merge(compare_q, bus.data_sram_wdata, bus.data_sram_wen);
                default:     ;
            endcase
        end
    end

    // A match in the same cycle as a software clear wins.
    assign irq_set = (compare_q != 32'h0) && (timer_q == compare_q);
    assign irq_clr = mmio_wr && (mmio_off == OFF_IRQ) &&
                     bus.data_sram_wen[0] && bus.data_sram_wdata[0];
    assign irq_d   = irq_set || (irq_q && !irq_clr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q   <= 32'h0;
            led_q     <= 16'h0;
            timer_q   <= 32'h0;
            compare_q <= 32'h0;
            irq_q     <= 1'b0;
        end else begin
            rdata_q   <= rdata_d;
            led_q     <= led_d;
            timer_q   <= timer_d;
            compare_q <= compare_d;
            irq_q     <= irq_d;
        end
    end

    // NOTE: the RAM array is deliberately not reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_en && !is_mmio) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.data_sram_wen[i]) mem[word_idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
            end
        end
    end

    assign bus.data_sram_rdata = rdata_q;
    assign led                 = led_q;
    assign timer_irq           = irq_q;
endmodule

// File: doc/data_sram_resp.md
DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning RAM word-index width (2^ADDR_W 32-bit words).
REQ-002 SHALL have parameter MMIO_BASE, default 32'hBFAF_0000, meaning the MMIO window base; only bits [31:16] are compared.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port data_sram_en  input  1  access request, one per cycle.
REQ-006 SHALL have port data_sram_wen  input  4  byte write enables, bit i covers byte i; 0 means read.
REQ-007 SHALL have port data_sram_addr  input  32  byte address, word-aligned; bits [1:0] ignored.
REQ-008 SHALL have port data_sram_wdata  input  32  write data.
REQ-009 SHALL have port data_sram_rdata  output  32  registered read data.
REQ-010 SHALL have port switch  input  8  external switch levels.
REQ-011 SHALL have port led  output  16  LED register value.
REQ-012 SHALL have port timer_irq  output  1  timer match flag (IRQ status bit0).

Function
REQ-013 SHALL decode addr[31:16]==MMIO_BASE[31:16] as MMIO; all other addresses SHALL decode as RAM, word index addr[ADDR_W+1:2], upper bits ignored (aliasing).
REQ-014 SHALL perform a read when en=1 and wen=0; rdata SHALL present the word on the first rising edge after the request (latency 1) and hold it until the next read.
REQ-015 SHALL perform a write when en=1 and wen!=0, updating only the enabled byte lanes at that edge; rdata SHALL hold its value on write cycles.
REQ-016 SHALL ignore all inputs when en=0; rdata and storage SHALL hold.
REQ-017 SHALL return the newly written data on a read issued in the cycle after a write to the same word.
REQ-018 SHALL implement MMIO offset 0x00 LED as read-write, bits [15:0]; bits [31:16] SHALL read 0; byte enables apply.
REQ-019 SHALL implement MMIO offset 0x04 SWITCH as read-only, zero-extended; writes SHALL be ignored.
REQ-020 SHALL implement MMIO offset 0x08 TIMER as read-write: +1 every cycle, wraps 0xFFFFFFFF->0; a write SHALL load the byte-merged value and suppress that cycle's increment.
REQ-021 SHALL implement MMIO offset 0x0C COMPARE as read-write with byte enables.
REQ-022 SHALL implement MMIO offset 0x10 IRQ_STATUS: bit0 SHALL be sticky-set on any cycle where COMPARE!=0 and the pre-increment TIMER==COMPARE; writing 1 to bit0 with wen[0]=1 SHALL clear it; bits [31:1] SHALL read 0.
REQ-023 SHALL give set priority over clear when both occur in the same cycle.
REQ-024 SHALL return 0 on reads of unmapped MMIO offsets and ignore writes to them.
REQ-025 SHALL return, on a TIMER read, the value held at the request edge.

Reset
REQ-026 SHALL, while rst=0, immediately force rdata, led, TIMER, COMPARE and IRQ_STATUS to 0, with timer_irq=0.
REQ-027 SHALL NOT reset RAM contents; RAM SHALL retain its prior values, undefined after power-up.
REQ-028 SHALL abort any in-flight access on reset assertion; the first access after rst deasserts SHALL behave normally.

Verification
REQ-029 SHALL verify: write 0x12345678, wen=4'hF, to addr 0x10; read 0x10 -> rdata=0x12345678 one cycle later.
REQ-030 SHALL verify: then write 0xAABBCCDD, wen=4'b0010, to 0x10; read -> 0x1234CC78.
REQ-031 SHALL verify aliasing: write 0xCAFEF00D to addr (1<<(ADDR_W+2))|0x10; read 0x10 -> 0xCAFEF00D.
REQ-032 SHALL verify wrap and load-over-increment: write TIMER=0xFFFFFFFF; TIMER=0 the following cycle; read returns small count with no skipped increment.
REQ-033 SHALL verify the IRQ: after reset, write COMPARE=0x100; timer_irq rises the cycle after TIMER==0x100 and stays high; write IRQ_STATUS=1 -> timer_irq low next cycle; a same-cycle match plus clear keeps it high.
REQ-034 SHALL verify reset mid-operation: write LED=0xBEEF, issue a read, assert rst=0 mid-cycle -> led=0, rdata=0, timer_irq=0 immediately; RAM word 0x10 still reads back after release.
